// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: default pixel width, pixel type and the pooling stage state encoding.
package cnn_pkg;

    localparam int WIDTH_BIT_DEFAULT = 16;

    typedef logic signed [WIDTH_BIT_DEFAULT-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } pool_state_e;

    function automatic int pool_out_size(input int in_size);
        return in_size / 2;
    endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Single-write, single-read line buffer holding one pooled pair maximum per output column.
module maxpool_linebuf
    import cnn_pkg::*;
#(
    parameter int  DEPTH  = 319,
    parameter int  ADDR_W = 9,
    parameter type data_t = pixel_t
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  data_t             wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output data_t             rd_data
);

    data_t mem [DEPTH];
    data_t rd_data_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/maxpool2_stream.sv
// Streaming 2x2 stride-2 signed max pool over a row-major IN_SIZE x IN_SIZE frame.
// Define MAXPOOL_RELU_EN to clamp every accepted pixel to max(pixel,0) before pooling.
module maxpool2_stream
    import cnn_pkg::*;
#(
    parameter int WIDTH_BIT = WIDTH_BIT_DEFAULT,
    parameter int IN_SIZE   = 638
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_BIT-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic                        done
);

    localparam int OUT_SIZE = pool_out_size(IN_SIZE);
    localparam int CNT_W    = $clog2(IN_SIZE);
    localparam int ADDR_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_SIZE - 1);
    localparam logic [CNT_W:0]   SPAN     = (CNT_W + 1)'(2 * OUT_SIZE);

    typedef logic signed [WIDTH_BIT-1:0] pix_t;

    function automatic pix_t pmax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    pool_state_e      state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    pix_t             hold_q, hold_d;
    logic             out_valid_q, out_valid_d;
    pix_t             out_data_q, out_data_d;
    logic             done_q, done_d;

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] col_half;
    pix_t              wr_data, rd_data, pix;
    logic              accept, last_beat, col_in_pool, row_in_pool;

    always_comb begin
`ifdef MAXPOOL_RELU_EN
        pix = (in_data < 0) ? '0 : in_data;
`else
        pix = in_data;
`endif
    end

    assign in_ready    = !done_q && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready && (state_q == IDLE || state_q == RUN);
    assign last_beat   = (col_q == LAST_IDX) && (row_q == LAST_IDX);
    // The trailing column/row of an odd-sized frame falls outside every window.
    assign col_in_pool = {1'b0, col_q} < SPAN;
    assign row_in_pool = {1'b0, row_q} < SPAN;
    assign col_half    = ADDR_W'(col_q >> 1);
    assign wr_data     = pmax(hold_q, pix);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        done_d      = done_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        if (accept) begin
            state_d = last_beat ? FLUSH : RUN;
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (col_in_pool && row_in_pool) begin
                if (!col_q[0]) begin
                    hold_d = pix;
                    // Prefetch the upper pair so it is ready when the window closes.
                    rd_en  = row_q[0];
                end else if (!row_q[0]) begin
                    wr_en = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = pmax(rd_data, wr_data);
                end
            end
        end

        if (state_q == FLUSH && (!out_valid_q || out_ready)) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    maxpool_linebuf #(
        .DEPTH  (OUT_SIZE),
        .ADDR_W (ADDR_W),
        .data_t (pix_t)
    ) u_linebuf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (col_half),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (col_half),
        .rd_data (rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
